// File: rtl/dot_stream_ctrl.sv
// dot_stream_ctrl
//   Front end for a two-lane multiply-add pipeline (C = A1*B1 + A2*B2, fixed
//   LAT-cycle latency). It accepts operand beats over valid/ready and drives
//   them into the pipeline. Returned C values are accumulated into one dot
//   product per vector, and the sum and beat count are presented on a
//   valid/ready output.
//
// Ports
//   clk_i, rst_ni                    clock, async active-low reset
//   in_valid_i / in_ready_o          operand beat handshake
//   in_a1_i..in_b2_i, in_last_i      operand pairs, end-of-vector marker
//   pipe_a1_o..pipe_b2_o             operands to the pipeline (zero when idle)
//   pipe_c_i                         pipeline result
//   out_valid_o / out_ready_i        result handshake
//   out_sum_o, out_count_o           dot product (mod 2^W), beat count (mod 2^CW)
module dot_stream_ctrl #(
  parameter int W   = 32,
  parameter int LAT = 2,
  parameter int CW  = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_a1_i,
  input  logic [W-1:0]  in_b1_i,
  input  logic [W-1:0]  in_a2_i,
  input  logic [W-1:0]  in_b2_i,
  input  logic          in_last_i,
  output logic [W-1:0]  pipe_a1_o,
  output logic [W-1:0]  pipe_b1_o,
  output logic [W-1:0]  pipe_a2_o,
  output logic [W-1:0]  pipe_b2_o,
  input  logic [W-1:0]  pipe_c_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_sum_o,
  output logic [CW-1:0] out_count_o
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LAT-1:0]  sr_q, sr_d;     // beat in flight, aligned to pipe_c at [LAT-1]
  logic [LAT-1:0]  lt_q, lt_d;     // last-beat tag, parallel to sr
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [CW-1:0]   count_q, count_d;
  logic            vld_q, vld_d;

  logic fire, done, take;

  assign fire = in_valid_i & in_ready_o;
  // Final C of the vector is on pipe_c this cycle.
  assign done = (state_q == DRAIN) & lt_q[LAT-1];
  assign take = vld_q & out_ready_i;

  // Operands are gated to zero when no beat is accepted, so the pipeline
  // samples them on the same edge that accepts the beat.
  assign pipe_a1_o = fire ? in_a1_i : '0;
  assign pipe_b1_o = fire ? in_b1_i : '0;
  assign pipe_a2_o = fire ? in_a2_i : '0;
  assign pipe_b2_o = fire ? in_b2_i : '0;

  assign out_valid_o = vld_q;
  assign out_sum_o   = sum_q;
  assign out_count_o = count_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (fire && in_last_i) state_d = DRAIN;
      DRAIN:   if (done)              state_d = HOLD;
      HOLD:    if (take)              state_d = ACCUM;
      default:                        state_d = ACCUM;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready_o = (state_q == ACCUM);
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    sr_d    = '0;
    lt_d    = '0;
    sr_d[0] = fire;
    lt_d[0] = fire & in_last_i;
    for (int i = 1; i < LAT; i++) begin
      sr_d[i] = sr_q[i-1];
      lt_d[i] = lt_q[i-1];
    end

    acc_d = acc_q;
    if (sr_q[LAT-1]) acc_d = acc_q + pipe_c_i;

    cnt_d = cnt_q;
    if (fire) cnt_d = cnt_q + CW'(1);

    sum_d   = sum_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (take) vld_d = 1'b0;

    // The final C is folded into the published sum directly; the running
    // accumulator and counter restart for the next vector.
    if (done) begin
      sum_d   = acc_q + pipe_c_i;
      count_d = cnt_q;
      vld_d   = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q    <= '0;
      lt_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      lt_q    <= lt_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_dot_stream_ctrl.sv
// Bench for dot_stream_ctrl with a behavioural two-stage multiply-add
// pipeline model. The driver pushes expected {sum, count} per vector into a
// queue, and a monitor pops and compares when the DUT presents a result.
module tb_dot_stream_ctrl;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic [W-1:0]  in_a1, in_b1, in_a2, in_b2;
  logic [W-1:0]  pipe_a1, pipe_b1, pipe_a2, pipe_b2, pipe_c;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;

  dot_stream_ctrl #(.W(W), .LAT(LAT), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a1_i(in_a1), .in_b1_i(in_b1), .in_a2_i(in_a2), .in_b2_i(in_b2),
    .in_last_i(in_last),
    .pipe_a1_o(pipe_a1), .pipe_b1_o(pipe_b1), .pipe_a2_o(pipe_a2), .pipe_b2_o(pipe_b2),
    .pipe_c_i(pipe_c),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_count_o(out_count)
  );

  always #5 clk = ~clk;

  // Pipeline model: operands sampled on edge k, C sampled by the DUT on k+2.
  // Not reset, so stale contents are present after reset.
  logic [W-1:0] s1 = 32'hDEAD_BEEF, s2 = 32'h0BAD_F00D;
  always @(posedge clk) begin
    s1 <= pipe_a1 * pipe_b1 + pipe_a2 * pipe_b2;
    s2 <= s1;
  end
  assign pipe_c = s2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [W-1:0] sum; logic [CW-1:0] cnt; } res_t;
  res_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  logic [W-1:0]  mdl_sum = '0;
  logic [CW-1:0] mdl_cnt = '0;
  int last_fire_cyc = 0;
  int fixed_hold = -1;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- result monitor / consumer ----------------
  logic          seen = 1'b0, hs_pend = 1'b0;
  logic [W-1:0]  snap_sum;
  logic [CW-1:0] snap_cnt;
  int            hold_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0; hs_pend = 1'b0; out_ready = 1'b0;
    end else begin
      if (hs_pend) begin
        check("out_valid_cleared", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
        hs_pend = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          snap_sum = out_sum;
          snap_cnt = out_count;
          check("latency", cyc, last_fire_cyc + LAT);
          hold_left = (fixed_hold >= 0) ? fixed_hold : $urandom_range(0, 3);
        end else begin
          check("sum_stable", out_sum, snap_sum);
          check("count_stable", out_count, snap_cnt);
        end
        check("in_ready_low_hold", in_ready, 0);
        if (hold_left == 0) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL spurious_out_valid: got sum %0h count %0d with no vector expected", out_sum, out_count);
          end else begin
            res_t e;
            e = exp_q.pop_front();
            check("out_sum", out_sum, e.sum);
            check("out_count", out_count, e.cnt);
          end
          out_ready = 1'b1;
          seen      = 1'b0;
          hs_pend   = 1'b1;
        end else begin
          hold_left--;
          out_ready = 1'b0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));  // no effect while idle
      end
    end
  end

  // Pipeline operands are the accepted beat, zero otherwise.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (in_valid && in_ready)
        check("pipe_fire", {pipe_a1, pipe_b1, pipe_a2, pipe_b2}, {in_a1, in_b1, in_a2, in_b2});
      else
        check("pipe_idle", {pipe_a1, pipe_b1, pipe_a2, pipe_b2}, 128'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [W-1:0] a1, b1, a2, b2, input logic last);
    int t = 0;
    in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2; in_last = last; in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);  // beat accepted on the posedge just passed
    mdl_sum = mdl_sum + a1 * b1 + a2 * b2;
    mdl_cnt = mdl_cnt + 1'b1;
    if (last) begin
      res_t r;
      r.sum = mdl_sum; r.cnt = mdl_cnt;
      exp_q.push_back(r);
      mdl_sum = '0; mdl_cnt = '0;
      last_fire_cyc = cyc;
      check("in_ready_low_drain", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_a1 = $urandom; in_b1 = $urandom; in_a2 = $urandom; in_b2 = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid || hs_pend) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) check("drain_timeout", 0, 1);
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_last = 0; in_a1 = 0; in_b1 = 0; in_a2 = 0; in_b2 = 0;
    out_ready = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    idle(3);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    idle(2);

    // Two-beat vector: 14 + 86 = 100
    send_beat(1, 2, 3, 4, 0);
    send_beat(5, 6, 7, 8, 1);
    wait_idle();

    // Single-beat vector: 49, count 1
    send_beat(7, 7, 0, 9, 1);
    wait_idle();

    // Accumulator wrap: 3 + 0xFFFFFFFF = 2 mod 2^32
    send_beat(32'h1_0000, 32'h1_0000, 3, 1, 0);
    send_beat(32'hFFFF_FFFF, 1, 0, 0, 1);
    wait_idle();

    // Gaps plus 5 cycles of backpressure: 6, count 3
    fixed_hold = 5;
    send_beat(1, 1, 1, 1, 0); idle(2);
    send_beat(1, 1, 1, 1, 0); idle(2);
    send_beat(1, 1, 1, 1, 1);
    wait_idle();
    fixed_hold = -1;

    // Reset mid-DRAIN: aborted vector must never appear
    send_beat(10, 10, 0, 0, 1);
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    #1;
    check("rst_drain_out_valid", out_valid, 0);
    check("rst_drain_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(2, 3, 0, 0, 1);
    wait_idle();

    // Randomized vectors, back-to-back and with gaps
    for (int v = 0; v < 25; v++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        logic [W-1:0] a1, b1, a2, b2;
        if ($urandom_range(0, 1) == 0) begin
          a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
          a2 = $urandom_range(0, 15); b2 = $urandom_range(0, 15);
        end else begin
          a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        end
        send_beat(a1, b1, a2, b2, b == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_stream_ctrl.md
Name: dot_stream_ctrl

Overview:
- Producer/consumer front end for the two-lane multiply-add pipeline, which computes C = A1*B1 + A2*B2 with a fixed 2-cycle latency.
- Accepts a stream of operand beats (two product pairs per beat) over a valid/ready handshake and drives them into the pipeline.
- Tracks in-flight beats with a latency-matched valid shift register and accumulates the returned C values into one dot-product per vector.
- Presents the finished sum, with a beat count, on a valid/ready output.

Parameters:
- W, 32, operand, product and accumulator width.
- LAT, 2, pipeline latency in clock edges from operand presentation to C sampled; legal range 1..8.
- CW, 16, beat-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a1, in_b1, in_a2, in_b2  in  W each  operand pairs for the beat.
- in_last  in  1  marks the final beat of a vector.
- pipe_a1, pipe_b1, pipe_a2, pipe_b2  out  W each  operands to the pipeline.
- pipe_c  in  W  pipeline result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  W  dot-product of the vector, mod 2^W.
- out_count  out  CW  number of beats in the vector, mod 2^CW.

Behaviour:
- Reset (async on rst_n low, all state):
  - state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_count=0.
  - Accumulator, beat counter and valid shift register sr[LAT-1:0] all cleared.
- fire = in_valid & in_ready.
- Pipeline drive:
  - pipe_* = in_* when fire, otherwise 0.
  - Driven combinationally, so the pipeline samples the operands on the same edge that accepts the beat.
- Valid tracking:
  - sr[0] <= fire; sr[i] <= sr[i-1].
  - pipe_c is meaningful on an edge only when sr[LAT-1]=1. In all other cycles it is ignored, including the stale, unreset pipeline contents right after reset.
- Accumulate: on each edge with sr[LAT-1]=1, acc <= acc + pipe_c, truncated to W bits (wraps, no saturation).
- Count: on each fire, cnt <= cnt + 1, wrapping.
- State ACCUM:
  - in_ready=1.
  - fire & in_last -> DRAIN, and a last-tag is loaded into a parallel LAT-deep shift register lt.
- State DRAIN:
  - in_ready=0.
  - On the edge where lt[LAT-1]=1, the final add completes and the following happen on that edge:
    - out_sum <= acc + pipe_c.
    - out_count <= cnt.
    - out_valid <= 1.
    - acc, cnt <= 0.
    - state -> HOLD.
- State HOLD:
  - in_ready=0; out_sum and out_count held stable.
  - out_valid & out_ready on an edge -> out_valid <= 0, state -> ACCUM.
  - in_ready returns to 1 on the following cycle; there is no same-cycle bypass.
- Latency: a last beat accepted on edge k gives out_valid=1 after edge k+LAT.
- Gaps: in_valid may deassert at any time mid-vector. Zero-driven pipeline inputs contribute nothing, and sr gates the accumulation anyway.
- A single-beat vector (in_last on the first beat) is legal: out_count=1.
- Reset mid-DRAIN or mid-HOLD discards the partial and pending result. In-flight pipeline results are never accumulated afterwards because sr was cleared.
- Simultaneous events:
  - out_ready asserted while not out_valid has no effect.
  - in_valid while in_ready=0 is not accepted, and the producer must hold its beat.

Test Plan:
- Two-beat vector, bench instantiating the real pipeline with LAT=2:
  - Stimulus: beat (1,2,3,4), then beat (5,6,7,8) with in_last.
  - Required: out_valid 2 edges after the last fire; out_sum=100 (14+86); out_count=2.
- Single-beat vector:
  - Stimulus: (7,7,0,9) with in_last.
  - Required: out_sum=49, out_count=1; in_ready low from the fire until the edge after the out handshake.
- Wrap:
  - Stimulus: (0x10000,0x10000,3,1) then (0xFFFFFFFF,1,0,0) last.
  - Required: out_sum=2 (0+3, plus 0xFFFFFFFF, mod 2^32).
- Gaps and backpressure:
  - Stimulus: 3 beats of (1,1,1,1) with 2 idle cycles between beats; out_ready held low 5 cycles after out_valid.
  - Required: out_sum=6 and out_count=3; both stable through the hold; in_ready=0 throughout the hold; handshake then clears out_valid.
- Reset mid-DRAIN:
  - Stimulus: rst_n low one cycle after a last beat (10,10,0,0); then vector (2,3,0,0) last.
  - Required: no out_valid from the aborted vector; next out_sum=6, out_count=1.
